mul_csv_arb: RTL and testbench

MUL_CSV_ARB -- requirements
Module: mul_csv_arb

---
 rtl/lau_pkg.sv | 9 +
 rtl/mul_csv_arb_mulcsvsgn.sv | 40 ++++
 rtl/mul_csv_arb.sv | 117 +++++++++++
 tb/tb_mul_csv_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lau_pkg.sv
// Shared types for the carry-save multiplier cluster: multiplier speed
// selection and the output-slot state of mul_csv_arb.
package lau_pkg;

  typedef enum logic {FAST, SMALL} speed_e;

  typedef enum logic {EMPTY, FULL} slot_state_e;

endpackage

// File: rtl/mul_csv_arb_mulcsvsgn.sv
// MulCsvSgn: signed (XS+XC)*Y with the product left in carry-save form.
// FAST skips the operand pre-add (two parallel partial products); SMALL pre-adds.
module MulCsvSgn
  import lau_pkg::*;
#(
  parameter int     widthX = 8,
  parameter int     widthY = 8,
  parameter speed_e speed  = FAST
) (
  input  logic signed [widthX-1:0]        XS,
  input  logic signed [widthX-1:0]        XC,
  input  logic signed [widthY-1:0]        Y,
  output logic        [widthX+widthY-1:0] PS,
  output logic        [widthX+widthY-1:0] PC
);

  localparam int WP = widthX + widthY;

  generate
    if (speed == FAST) begin : g_fast
      logic signed [WP-1:0] ps_s, pc_s;
      always_comb begin
        ps_s = $signed(WP'(XS)) * $signed(WP'(Y));
        pc_s = $signed(WP'(XC)) * $signed(WP'(Y));
      end
      assign PS = ps_s;
      assign PC = pc_s;
    end else begin : g_small
      logic signed [widthX-1:0] xsum;
      logic signed [WP-1:0]     prod;
      always_comb begin
        xsum = XS + XC;
        prod = $signed(WP'(xsum)) * $signed(WP'(Y));
      end
      assign PS = prod;
      assign PC = '0;
    end
  endgenerate

endmodule

// File: rtl/mul_csv_arb.sv
// Round-robin arbiter sharing one MulCsvSgn among numReq requesters, with a
// one-entry output slot. Define MUL_CSV_ARB_FINAL_ADD_EN to add the RspP output.
module mul_csv_arb
  import lau_pkg::*;
#(
  parameter int     widthX = 8,
  parameter int     widthY = 8,
  parameter int     numReq = 4,
  parameter speed_e speed  = FAST
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [numReq-1:0]                 ReqValid,
  output logic [numReq-1:0]                 ReqReady,
  input  logic [numReq*widthX-1:0]          ReqXS,
  input  logic [numReq*widthX-1:0]          ReqXC,
  input  logic [numReq*widthY-1:0]          ReqY,
  output logic                              RspValid,
  input  logic                              RspReady,
  output logic [$clog2(numReq)-1:0]         RspId,
  output logic [widthX+widthY-1:0]          RspPS,
  output logic [widthX+widthY-1:0]          RspPC
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
  ,output logic [widthX+widthY-1:0]         RspP
`endif
);

  localparam int WP = widthX + widthY;
  localparam int IW = $clog2(numReq);

  slot_state_e           state_q;
  logic [IW-1:0]         ptr_q, ptr_d, id_q;
  logic [WP-1:0]         ps_q, pc_q;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any, avail, take;
  logic signed [widthX-1:0] mux_xs, mux_xc;
  logic signed [widthY-1:0] mux_y;
  logic [WP-1:0]         mul_ps, mul_pc;

  // Walk candidates from the farthest offset down so the nearest to ptr wins.
  always_comb begin
    int unsigned cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = numReq - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= numReq) cand = cand - numReq;
      if (ReqValid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
  end

  assign avail = (state_q == EMPTY) || RspReady;
  assign take  = avail && gnt_any && !RST;
  assign ptr_d = (gnt_idx == IW'(numReq - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    ReqReady = '0;
    if (take) ReqReady[gnt_idx] = 1'b1;
  end

  assign mux_xs = ReqXS[gnt_idx*widthX +: widthX];
  assign mux_xc = ReqXC[gnt_idx*widthX +: widthX];
  assign mux_y  = ReqY[gnt_idx*widthY +: widthY];

  MulCsvSgn #(
    .widthX(widthX),
    .widthY(widthY),
    .speed (speed)
  ) u_mul (
    .XS(mux_xs),
    .XC(mux_xc),
    .Y (mux_y),
    .PS(mul_ps),
    .PC(mul_pc)
  );

`ifdef MUL_CSV_ARB_FINAL_ADD_EN
  logic [WP-1:0] p_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      ps_q    <= '0;
      pc_q    <= '0;
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
      p_q     <= '0;
`endif
    end else if (take) begin
      state_q <= FULL;
      ptr_q   <= ptr_d;
      id_q    <= gnt_idx;
      ps_q    <= mul_ps;
      pc_q    <= mul_pc;
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
      p_q     <= mul_ps + mul_pc;
`endif
    end else if (state_q == FULL && RspReady) begin
      state_q <= EMPTY;
    end
  end

  assign RspValid = (state_q == FULL);
  assign RspId    = id_q;
  assign RspPS    = ps_q;
  assign RspPC    = pc_q;
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
  assign RspP     = p_q;
`endif

endmodule

// File: tb/tb_mul_csv_arb.sv
// Bench for mul_csv_arb (widthX=widthY=8, numReq=4): vector table, directed
// slot/reset sequences and a randomized run against a behavioural model.
module tb_mul_csv_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ReqValid, ReqReady;
  logic [31:0] ReqXS, ReqXC, ReqY;
  logic        RspValid, RspReady;
  logic [1:0]  RspId;
  logic [15:0] RspPS, RspPC;
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
  logic [15:0] RspP;
`endif

  always #5 CLK = ~CLK;

  mul_csv_arb #(.widthX(8), .widthY(8), .numReq(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ReqValid(ReqValid),
    .ReqReady(ReqReady),
    .ReqXS   (ReqXS),
    .ReqXC   (ReqXC),
    .ReqY    (ReqY),
    .RspValid(RspValid),
    .RspReady(RspReady),
    .RspId   (RspId),
    .RspPS   (RspPS),
    .RspPC   (RspPC)
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    ,.RspP   (RspP)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic [1:0] id, input logic [15:0] sum);
    logic [15:0] s;
    s = RspPS + RspPC;
    chk({nm, "_valid"}, RspValid, 1'b1);
    chk({nm, "_id"}, RspId, id);
    chk({nm, "_sum"}, s, sum);
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    chk({nm, "_p"}, RspP, sum);
`endif
  endtask

  task automatic do_reset();
    RST = 1'b0;
    ReqValid = 4'b1111;
    RspReady = 1'b0;
    ReqXS = '0; ReqXC = '0; ReqY = '0;
    #1 RST = 1'b1;
    #1;
    chk("rst_valid", RspValid, 1'b0);
    chk("rst_ready", ReqReady, 4'b0000);
    chk("rst_ps", RspPS, 16'h0);
    chk("rst_pc", RspPC, 16'h0);
    chk("rst_id", RspId, 2'd0);
    ReqValid = 4'b0000;
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] xs, xc, y;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [15:0] sum;
  } vec_t;

  vec_t tbl[8];

  // Randomized model state
  logic [3:0]        pend;
  logic signed [7:0] mxs[4], mxc[4], my[4];
  bit                mfull;
  int                mptr, mid, g;
  logic [15:0]       msum;

  initial begin
    logic [15:0] hold_ps, hold_pc;
    logic signed [7:0] s8;
    int p;
    logic [3:0] exp_rdy;

    tbl[0] = '{vld:4'b0001, xs:32'h00000003, xc:32'h00000002, y:32'h000000FC, rr:1'b1,
               rdy:4'b0001, rv:1'b0, id:2'd0, sum:16'h0000};
    tbl[1] = '{vld:4'b1111, xs:32'h7F0AFD05, xc:32'h00EC0101, y:32'h7FFB0907, rr:1'b1,
               rdy:4'b0010, rv:1'b1, id:2'd0, sum:16'hFFEC};
    tbl[2] = '{vld:4'b1111, xs:32'h7F0AFD05, xc:32'h00EC0101, y:32'h7FFB0907, rr:1'b1,
               rdy:4'b0100, rv:1'b1, id:2'd1, sum:16'hFFEE};
    tbl[3] = '{vld:4'b1111, xs:32'h7F0AFD05, xc:32'h00EC0101, y:32'h7FFB0907, rr:1'b1,
               rdy:4'b1000, rv:1'b1, id:2'd2, sum:16'h0032};
    tbl[4] = '{vld:4'b1111, xs:32'h7F0AFD05, xc:32'h00EC0101, y:32'h7FFB0907, rr:1'b1,
               rdy:4'b0001, rv:1'b1, id:2'd3, sum:16'h3F01};
    tbl[5] = '{vld:4'b1111, xs:32'h7F0AFD05, xc:32'h00EC0101, y:32'h7FFB0907, rr:1'b1,
               rdy:4'b0010, rv:1'b1, id:2'd0, sum:16'h002A};
    tbl[6] = '{vld:4'b0000, xs:32'h0, xc:32'h0, y:32'h0, rr:1'b1,
               rdy:4'b0000, rv:1'b1, id:2'd1, sum:16'hFFEE};
    tbl[7] = '{vld:4'b0000, xs:32'h0, xc:32'h0, y:32'h0, rr:1'b1,
               rdy:4'b0000, rv:1'b0, id:2'd0, sum:16'h0000};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      ReqValid = tbl[i].vld; ReqXS = tbl[i].xs; ReqXC = tbl[i].xc; ReqY = tbl[i].y;
      RspReady = tbl[i].rr;
      @(negedge CLK);
      chk("tbl_ready", ReqReady, tbl[i].rdy);
      chk("tbl_rspvalid", RspValid, tbl[i].rv);
      if (tbl[i].rv) chk_rsp("tbl", tbl[i].id, tbl[i].sum);
      @(posedge CLK); #1;
    end

    // Back-pressure: slot held stable, no grants, then drain+accept together
    do_reset();
    ReqValid = 4'b0100; ReqXS = 32'h00060000; ReqXC = 32'h00FF0000; ReqY = 32'h00030000;
    RspReady = 1'b1;
    @(negedge CLK);
    chk("bp_first_ready", ReqReady, 4'b0100);
    @(posedge CLK); #1;
    ReqXS = 32'h00020000; ReqXC = 32'h00020000; ReqY = 32'h00F60000;
    RspReady = 1'b0;
    hold_ps = RspPS; hold_pc = RspPC;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_stall_ready", ReqReady, 4'b0000);
      chk_rsp("bp_stall", 2'd2, 16'h000F);
      chk("bp_ps_stable", RspPS, hold_ps);
      chk("bp_pc_stable", RspPC, hold_pc);
      @(posedge CLK); #1;
    end
    RspReady = 1'b1;
    @(negedge CLK);
    chk("bp_drain_ready", ReqReady, 4'b0100);
    chk_rsp("bp_drain", 2'd2, 16'h000F);
    @(posedge CLK); #1;
    ReqValid = 4'b0000;
    @(negedge CLK);
    chk_rsp("bp_next", 2'd2, 16'hFFD8);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_empty", RspValid, 1'b0);
    @(posedge CLK); #1;

    // Reset while a result is held
    do_reset();
    ReqValid = 4'b0010; ReqXS = 32'h00000100; ReqXC = 32'h00000100; ReqY = 32'h00000100;
    RspReady = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 4'b1111; RspReady = 1'b0;
    @(negedge CLK);
    chk_rsp("mr_before", 2'd1, 16'h0002);
    #2 RST = 1'b1;
    #1;
    chk("mr_valid", RspValid, 1'b0);
    chk("mr_ready", ReqReady, 4'b0000);
    chk("mr_ps", RspPS, 16'h0);
    chk("mr_pc", RspPC, 16'h0);
    chk("mr_id", RspId, 2'd0);
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    chk("mr_p", RspP, 16'h0);
`endif
    @(posedge CLK); #1 RST = 1'b0;
    RspReady = 1'b1;
    @(negedge CLK);
    chk("mr_after_ready", ReqReady, 4'b0001);
    chk("mr_after_valid", RspValid, 1'b0);
    @(posedge CLK); #1;

    // Most-negative operands
    ReqValid = 4'b0001; ReqXS = 32'h00000080; ReqXC = 32'h0; ReqY = 32'h00000080;
    @(negedge CLK);
    chk("neg_ready", ReqReady, 4'b0001);
    @(posedge CLK); #1;
    ReqValid = 4'b0000;
    @(negedge CLK);
    chk_rsp("neg", 2'd0, 16'h4000);
    @(posedge CLK); #1;

    // Randomized run against the model
    do_reset();
    pend = '0; mfull = 0; mptr = 0; mid = 0; msum = '0;
    for (int i = 0; i < 4; i++) begin mxs[i] = '0; mxc[i] = '0; my[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          mxs[i] = 8'($urandom_range(0, 127) - 64);
          mxc[i] = 8'($urandom_range(0, 127) - 64);
          my[i]  = 8'($urandom);
        end
      end
      ReqValid = pend;
      for (int i = 0; i < 4; i++) begin
        ReqXS[i*8 +: 8] = mxs[i];
        ReqXC[i*8 +: 8] = mxc[i];
        ReqY[i*8 +: 8]  = my[i];
      end
      RspReady = ($urandom % 10) < 7;
      g = -1;
      if (!mfull || RspReady)
        for (int k = 0; k < 4; k++)
          if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      @(negedge CLK);
      chk("rnd_ready", ReqReady, exp_rdy);
      chk("rnd_valid", RspValid, mfull);
      if (mfull) chk_rsp("rnd", 2'(mid), msum);
      @(posedge CLK);
      if (g >= 0) begin
        s8 = mxs[g] + mxc[g];
        p = int'(s8) * int'(my[g]);
        msum = p[15:0];
        mfull = 1; mid = g; mptr = (g + 1) % 4;
        pend[g] = 1'b0;
      end else if (mfull && RspReady) begin
        mfull = 0;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
